// File: rtl/xilinx_primitive_pkg.sv
// Shared types and helpers for the Xilinx-style BRAM wrappers.
// Write-mode and state enums plus the lane-count helper used by the banks.
package xilinx_primitive_pkg;

   typedef enum logic [1:0] {
      WR_FIRST,
      RD_FIRST,
      NO_CHANGE
   } wr_mode_e;

   typedef enum logic {
      CLEAR,
      RUN
   } sp_arr_state_e;

   function automatic int f_num_lanes(input int width, input int byte_w);
      return (width + byte_w - 1) / byte_w;
   endfunction

endpackage

// File: rtl/xilinx_sp_bram_bank.sv
// One BANK_DEPTH x DATA_WIDTH inferred block RAM with per-lane write enables,
// selectable write mode and an optional second output register.
module xilinx_sp_bram_bank
   import xilinx_primitive_pkg::*;
#(
   parameter int       DATA_WIDTH = 32,
   parameter int       BANK_DEPTH = 1024,
   parameter int       BYTE_WIDTH = 8,
   parameter int       DO_REG     = 0,
   parameter wr_mode_e WRITE_MODE = WR_FIRST,
   localparam int      NB         = f_num_lanes(DATA_WIDTH, BYTE_WIDTH),
   localparam int      BAW        = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [NB-1:0]         we,
   input  logic [BAW-1:0]        addr,
   input  logic [DATA_WIDTH-1:0] di,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] wmask;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] dout_p1;

   // Top lane may be narrower than BYTE_WIDTH; the bit mask handles that naturally.
   always_comb begin
      wmask = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         wmask[i] = we[i / BYTE_WIDTH];
      end
   end

   assign rd_word = mem[addr];
   assign merged  = (rd_word & ~wmask) | (di & wmask);

   // Stage p1: array write and primary output latch
   always_ff @(posedge clk) begin
      if (en) begin
         if (|we) begin
            mem[addr] <= merged;
         end
         case (WRITE_MODE)
            WR_FIRST: dout_p1 <= merged;
            RD_FIRST: dout_p1 <= rd_word;
            default: begin
               if (!(|we)) begin
                  dout_p1 <= rd_word;
               end
            end
         endcase
      end
   end

   // Stage p2: optional output register
   generate
      if (DO_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] dout_p2;
         always_ff @(posedge clk) begin
            dout_p2 <= dout_p1;
         end
         assign dout = dout_p2;
      end else begin : g_noreg
         assign dout = dout_p1;
      end
   endgenerate

endmodule

// File: rtl/xilinx_sp_bram_array.sv
// Single-port RAM tiled from BRAM banks (rows for depth), with post-reset
// clear sequencer, row decode, read-valid/row-select pipeline and output mux.
module xilinx_sp_bram_array
   import xilinx_primitive_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    DEPTH          = 4096,
   parameter int                    BANK_DEPTH     = 1024,
   parameter int                    BYTE_WIDTH     = 8,
   parameter int                    DO_REG         = 0,
   parameter wr_mode_e              WRITE_MODE     = WR_FIRST,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VAL      = '0,
   parameter logic [DATA_WIDTH-1:0] SRVAL          = '0,
   localparam int                   NB             = f_num_lanes(DATA_WIDTH, BYTE_WIDTH),
   localparam int                   AW             = $clog2(DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic [NB-1:0]         WE,
   input  logic [AW-1:0]         ADDR,
   input  logic [DATA_WIDTH-1:0] DI,
   output logic [DATA_WIDTH-1:0] DO,
   output logic                  DO_VALID,
   output logic                  ADDR_ERR,
   output logic                  READY
);

   localparam int BAW   = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int NROWS = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
   localparam int RW    = (NROWS > 1) ? $clog2(NROWS) : 1;
   localparam int XW    = AW + BAW;

   sp_arr_state_e state, state_nx;
   logic [BAW-1:0] cnt, cnt_nx;
   logic           clr_act;

   logic [XW-1:0]  addr_x;
   logic [BAW-1:0] local_addr;
   logic [RW-1:0]  row;
   logic           in_range;
   logic           accept;
   logic           nc_wr;
   logic           upd;

   logic [NROWS-1:0]      bank_en;
   logic [NB-1:0]         bank_we;
   logic [BAW-1:0]        bank_addr;
   logic [DATA_WIDTH-1:0] bank_di;
   logic [DATA_WIDTH-1:0] bank_do [NROWS];

   logic          vld_p1, err_p1, srv_p1;
   logic [RW-1:0] row_p1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      clr_act  = 1'b0;
      case (state)
         CLEAR: begin
            clr_act = 1'b1;
            cnt_nx  = cnt + 1'b1;
            if (cnt == BAW'(BANK_DEPTH - 1)) begin
               state_nx = RUN;
            end
         end
         default: ;
      endcase
   end

   assign READY = (state == RUN);

   assign addr_x     = XW'(ADDR);
   assign local_addr = addr_x[BAW-1:0];
   assign row        = RW'(addr_x >> BAW);
   assign in_range   = (addr_x < XW'(DEPTH));
   assign accept     = EN & READY;
   // NO_CHANGE writes leave DO untouched, so they must not move the output select.
   assign nc_wr      = (WRITE_MODE == NO_CHANGE) & (|WE) & in_range;
   assign upd        = accept & ~nc_wr;

   // Clear drives every row at once; otherwise only the decoded row is enabled.
   always_comb begin
      bank_we   = clr_act ? '1 : WE;
      bank_addr = clr_act ? cnt : local_addr;
      bank_di   = clr_act ? CLEAR_VAL : DI;
      bank_en   = '0;
      for (int r = 0; r < NROWS; r++) begin
         bank_en[r] = clr_act | (accept & in_range & (row == RW'(r)));
      end
   end

   generate
      for (genvar r = 0; r < NROWS; r++) begin : g_row
         xilinx_sp_bram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .BANK_DEPTH (BANK_DEPTH),
            .BYTE_WIDTH (BYTE_WIDTH),
            .DO_REG     (DO_REG),
            .WRITE_MODE (WRITE_MODE)
         ) u_bank (
            .clk  (CLK),
            .en   (bank_en[r]),
            .we   (bank_we),
            .addr (bank_addr),
            .di   (bank_di),
            .dout (bank_do[r])
         );
      end
   endgenerate

   // Stage p1: valid, error flag and output select, aligned with bank read
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
         srv_p1 <= 1'b1;
      end else begin
         vld_p1 <= upd;
         err_p1 <= accept & ~in_range;
         if (upd) begin
            srv_p1 <= ~in_range;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (upd & in_range) begin
         row_p1 <= row;
      end
   end

   // Stage p2: tracks the bank output register when DO_REG is set
   generate
      if (DO_REG != 0) begin : g_oreg
         logic          vld_p2, err_p2, srv_p2;
         logic [RW-1:0] row_p2;
         always_ff @(posedge CLK) begin
            if (RST) begin
               vld_p2 <= 1'b0;
               err_p2 <= 1'b0;
               srv_p2 <= 1'b1;
            end else begin
               vld_p2 <= vld_p1;
               err_p2 <= err_p1;
               srv_p2 <= srv_p1;
            end
         end
         always_ff @(posedge CLK) begin
            row_p2 <= row_p1;
         end
         assign DO_VALID = vld_p2;
         assign ADDR_ERR = err_p2;
         assign DO       = srv_p2 ? SRVAL : bank_do[row_p2];
      end else begin : g_noreg
         assign DO_VALID = vld_p1;
         assign ADDR_ERR = err_p1;
         assign DO       = srv_p1 ? SRVAL : bank_do[row_p1];
      end
   endgenerate

endmodule

// File: tb/tb_xilinx_sp_bram_array.sv
// Directed bench: clear sequencing, decode, byte lanes, write modes,
// DO_REG latency and out-of-range handling across several configurations.
module tb_xilinx_sp_bram_array;
   import xilinx_primitive_pkg::*;

   localparam logic [31:0] SRV = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [3:0]  we;
   logic [11:0] addr;
   logic [31:0] di;

   logic [31:0] do0, do1, do2, do3, do4;
   logic        v0, v1, v2, v3, v4;
   logic        e0, e1, e2, e3, e4;
   logic        r0, r1, r2, r3, r4;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   xilinx_sp_bram_array #(.DO_REG(0), .WRITE_MODE(WR_FIRST), .SRVAL(SRV)) u0 (
      .CLK(clk), .RST(rst), .EN(en), .WE(we), .ADDR(addr), .DI(di),
      .DO(do0), .DO_VALID(v0), .ADDR_ERR(e0), .READY(r0));
   xilinx_sp_bram_array #(.DO_REG(1), .WRITE_MODE(WR_FIRST), .SRVAL(SRV)) u1 (
      .CLK(clk), .RST(rst), .EN(en), .WE(we), .ADDR(addr), .DI(di),
      .DO(do1), .DO_VALID(v1), .ADDR_ERR(e1), .READY(r1));
   xilinx_sp_bram_array #(.DO_REG(0), .WRITE_MODE(RD_FIRST), .SRVAL(SRV)) u2 (
      .CLK(clk), .RST(rst), .EN(en), .WE(we), .ADDR(addr), .DI(di),
      .DO(do2), .DO_VALID(v2), .ADDR_ERR(e2), .READY(r2));
   xilinx_sp_bram_array #(.DO_REG(0), .WRITE_MODE(NO_CHANGE), .SRVAL(SRV)) u3 (
      .CLK(clk), .RST(rst), .EN(en), .WE(we), .ADDR(addr), .DI(di),
      .DO(do3), .DO_VALID(v3), .ADDR_ERR(e3), .READY(r3));
   xilinx_sp_bram_array #(.DEPTH(3000), .DO_REG(0), .WRITE_MODE(WR_FIRST), .SRVAL(SRV)) u4 (
      .CLK(clk), .RST(rst), .EN(en), .WE(we), .ADDR(addr), .DI(di),
      .DO(do4), .DO_VALID(v4), .ADDR_ERR(e4), .READY(r4));

   typedef struct {
      logic        en;
      logic [3:0]  we;
      logic [11:0] addr;
      logic [31:0] di;
      logic [31:0] exp_do;
      logic        exp_vld;
      logic        exp_err;
   } vec_t;

   vec_t vecs[15];
   vec_t prev;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [3:0] w, input logic [11:0] a, input logic [31:0] d);
      en   = e;
      we   = w;
      addr = a;
      di   = d;
   endtask

   initial begin
      int  n;
      logic early;

      vecs[0]  = '{1'b1, 4'h0, 12'h000, 32'h0,          32'h0000_0000, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 4'h0, 12'h3FF, 32'h0,          32'h0000_0000, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 4'h0, 12'h400, 32'h0,          32'h0000_0000, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 4'h0, 12'hFFF, 32'h0,          32'h0000_0000, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 4'hF, 12'hC00, 32'hDEAD_BEEF,  32'hDEAD_BEEF, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 4'h0, 12'hC00, 32'h0,          32'hDEAD_BEEF, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 4'h0, 12'h400, 32'h0,          32'h0000_0000, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 4'h0, 12'hC00, 32'h0,          32'h0000_0000, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 4'hF, 12'h123, 32'h1122_3344,  32'h1122_3344, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 4'h5, 12'h123, 32'hAABB_CCDD,  32'h11BB_33DD, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 4'h0, 12'h123, 32'h0,          32'h11BB_33DD, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 4'h1, 12'h800, 32'h0000_00AB,  32'h0000_00AB, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 4'h0, 12'h800, 32'h0,          32'h0000_00AB, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 4'hF, 12'h000, 32'hFFFF_FFFF,  32'h0000_00AB, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 4'h0, 12'h000, 32'h0,          32'h0000_0000, 1'b1, 1'b0};

      // reset state
      rst = 1'b1;
      drive(1'b0, 4'h0, 12'h000, 32'h0);
      tick();
      chk("rst_ready", 32'(r0), 32'h0);
      chk("rst_do", do0, SRV);
      chk("rst_vld", 32'(v0), 32'h0);
      chk("rst_err", 32'(e0), 32'h0);
      chk("rst_do_dlyreg", do1, SRV);
      chk("rst_do_depth3000", do4, SRV);
      rst = 1'b0;

      // first clear, interrupted at cycle 500; EN pulses must be ignored
      early = 1'b0;
      for (int c = 1; c <= 500; c++) begin
         if (c >= 490 && c < 499) drive(1'b1, 4'hF, 12'h000, 32'hFFFF_FFFF);
         else drive(1'b0, 4'h0, 12'h000, 32'h0);
         tick();
         if (r0) early = 1'b1;
         if (c >= 490) begin
            chk("clear_en_vld", 32'(v0), 32'h0);
            chk("clear_en_vld_dlyreg", 32'(v1), 32'h0);
         end
      end
      chk("ready_before_rst2", 32'(early), 32'h0);

      rst = 1'b1;
      tick();
      chk("rst2_ready", 32'(r0), 32'h0);
      rst = 1'b0;
      n = 0;
      while (!r0 && n < 2000) begin
         tick();
         n++;
      end
      chk("ready_latency", 32'(n), 32'd1024);
      chk("ready_dlyreg", 32'(r1), 32'h1);

      // table: u0 compared on the same cycle, u1 one cycle later
      prev.exp_do  = SRV;
      prev.exp_vld = 1'b0;
      prev.exp_err = 1'b0;
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].di);
         tick();
         chk($sformatf("vec%0d_do", i), do0, vecs[i].exp_do);
         chk($sformatf("vec%0d_vld", i), 32'(v0), 32'(vecs[i].exp_vld));
         chk($sformatf("vec%0d_err", i), 32'(e0), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_do_dlyreg", i), do1, prev.exp_do);
         chk($sformatf("vec%0d_vld_dlyreg", i), 32'(v1), 32'(prev.exp_vld));
         prev = vecs[i];
      end
      drive(1'b0, 4'h0, 12'h000, 32'h0);
      tick();
      chk("tail_do_dlyreg", do1, prev.exp_do);
      chk("tail_vld_dlyreg", 32'(v1), 32'(prev.exp_vld));
      chk("tail_vld", 32'(v0), 32'h0);

      // write modes: old word 0x5, new write 0x9
      drive(1'b1, 4'hF, 12'h010, 32'h5);
      tick();
      chk("wm_w5_wrfirst", do0, 32'h5);
      chk("wm_w5_rdfirst", do2, 32'h0);
      chk("wm_w5_nochange_vld", 32'(v3), 32'h0);
      drive(1'b1, 4'h0, 12'h010, 32'h0);
      tick();
      chk("wm_rd_nochange", do3, 32'h5);
      chk("wm_rd_nochange_vld", 32'(v3), 32'h1);
      drive(1'b1, 4'hF, 12'h010, 32'h9);
      tick();
      chk("wm_w9_wrfirst", do0, 32'h9);
      chk("wm_w9_rdfirst", do2, 32'h5);
      chk("wm_w9_rdfirst_vld", 32'(v2), 32'h1);
      chk("wm_w9_nochange", do3, 32'h5);
      chk("wm_w9_nochange_vld", 32'(v3), 32'h0);
      drive(1'b1, 4'h0, 12'h010, 32'h0);
      tick();
      chk("wm_rd9_rdfirst", do2, 32'h9);
      chk("wm_rd9_nochange", do3, 32'h9);

      // DEPTH=3000 instance: out-of-range flagging and aliasing
      drive(1'b1, 4'hF, 12'd428, 32'h0000_1428);
      tick();
      chk("oor_w428", do4, 32'h0000_1428);
      chk("oor_w428_err", 32'(e4), 32'h0);
      drive(1'b1, 4'hF, 12'd3500, 32'hFFFF_FFFF);
      tick();
      chk("oor_w3500_do", do4, SRV);
      chk("oor_w3500_vld", 32'(v4), 32'h1);
      chk("oor_w3500_err", 32'(e4), 32'h1);
      chk("oor_w3500_inrange_err", 32'(e0), 32'h0);
      drive(1'b1, 4'h0, 12'd428, 32'h0);
      tick();
      chk("oor_alias428", do4, 32'h0000_1428);
      chk("oor_alias428_err", 32'(e4), 32'h0);
      drive(1'b1, 4'h0, 12'd3000, 32'h0);
      tick();
      chk("oor_r3000_do", do4, SRV);
      chk("oor_r3000_vld", 32'(v4), 32'h1);
      chk("oor_r3000_err", 32'(e4), 32'h1);
      drive(1'b0, 4'h0, 12'd0, 32'h0);
      tick();
      chk("oor_idle_do", do4, SRV);
      chk("oor_idle_vld", 32'(v4), 32'h0);
      chk("oor_idle_err", 32'(e4), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
